// File: rtl/xor_sched_pkg.sv
// Shared types and helpers for the bit-serial XOR scheduler.
// State encoding and the round-robin pointer increment.
package xor_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Next round-robin pointer: one past the last winner, wrapping at nreq.
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nreq);
      return (ptr + 1 >= nreq) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/my_xor.sv
// Gate-level XOR cell built from four NAND gates.
// Shared by the scheduler as its only XOR datapath.
module my_xor (
   input  logic i_a,
   input  logic i_b,
   output logic o_y
);

   logic w_n1;
   logic w_n2;
   logic w_n3;

   assign w_n1 = ~(i_a & i_b);
   assign w_n2 = ~(i_a & w_n1);
   assign w_n3 = ~(i_b & w_n1);
   assign o_y  = ~(w_n2 & w_n3);

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after the
// pointer, scanning upward with wrap-around.
module rr_pick #(
   parameter int NREQ = 2,
   parameter int IDW  = 1
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   output logic [IDW-1:0]  o_winner,
   output logic            o_valid
);

   // NOTE: every output of an always_comb gets a default first, so no path
   // through the block leaves it unassigned and a latch is never inferred.
   always_comb begin
      o_winner = '0;
      o_valid  = 1'b0;
      // Scan from the farthest offset down so the nearest request overwrites last.
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (i_req[(int'(i_ptr) + k) % NREQ]) begin
            o_winner = IDW'((int'(i_ptr) + k) % NREQ);
            o_valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/xor_serial_sched.sv
// Round-robin scheduler sharing one bit-serial XOR cell between NREQ
// requesters; operands are shifted LSB-first and the result returned with a done pulse.
module xor_serial_sched
   import xor_sched_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int NREQ  = 2,
   parameter int IDW   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] a_in,
   input  logic [NREQ*WIDTH-1:0] b_in,
   output logic [NREQ-1:0]       grant,
   output logic                  busy,
   output logic                  done,
   output logic [IDW-1:0]        done_id,
   output logic [WIDTH-1:0]      result
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t           r_state;
   logic [IDW-1:0]   r_rr_ptr;
   logic [IDW-1:0]   r_winner;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic [WIDTH-1:0] r_res;

   logic [IDW-1:0]   w_pick;
   logic             w_pick_valid;
   logic             w_xor;
   logic [WIDTH-1:0] w_res_next;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_pick (
      .i_req    (req),
      .i_ptr    (r_rr_ptr),
      .o_winner (w_pick),
      .o_valid  (w_pick_valid)
   );

   my_xor u_my_xor (
      .i_a (r_opa[0]),
      .i_b (r_opb[0]),
      .o_y (w_xor)
   );

   // New bit enters at the MSB; written this way so WIDTH==1 needs no slice.
   always_comb begin
      w_res_next            = r_res >> 1;
      w_res_next[WIDTH-1]   = w_xor;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order in this block.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_rr_ptr <= '0;
         r_winner <= '0;
         r_cnt    <= '0;
         r_opa    <= '0;
         r_opb    <= '0;
         r_res    <= '0;
         grant    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         done_id  <= '0;
         result   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pick_valid) begin
                  grant    <= NREQ'(1) << w_pick;
                  busy     <= 1'b1;
                  r_cnt    <= '0;
                  r_opa    <= a_in[w_pick*WIDTH +: WIDTH];
                  r_opb    <= b_in[w_pick*WIDTH +: WIDTH];
                  r_winner <= w_pick;
                  r_rr_ptr <= IDW'(rr_next(32'(w_pick), NREQ));
                  r_state  <= SHIFT;
               end
            end
            SHIFT: begin
               r_res <= w_res_next;
               r_opa <= r_opa >> 1;
               r_opb <= r_opb >> 1;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(WIDTH - 1)) begin
                  r_state <= DONE;
                  done    <= 1'b1;
                  done_id <= r_winner;
                  result  <= w_res_next;
               end
            end
            DONE: begin
               r_state <= IDLE;
               grant   <= '0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               grant   <= '0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xor_serial_sched.sv
// Scoreboard bench for xor_serial_sched (WIDTH=4, NREQ=2): stimulus pushes
// expected {id, result}; a monitor pops and compares on every done pulse.
module tb_xor_serial_sched;

   localparam int WIDTH = 4;
   localparam int NREQ  = 2;
   localparam int IDW   = 1;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] a_in;
   logic [NREQ*WIDTH-1:0] b_in;
   logic [NREQ-1:0]       grant;
   logic                  busy;
   logic                  done;
   logic [IDW-1:0]        done_id;
   logic [WIDTH-1:0]      result;

   typedef struct {
      int         id;
      logic [3:0] res;
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   n_done = 0;

   always #5 clk = ~clk;

   xor_serial_sched #(
      .WIDTH (WIDTH),
      .NREQ  (NREQ),
      .IDW   (IDW)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .a_in    (a_in),
      .b_in    (b_in),
      .grant   (grant),
      .busy    (busy),
      .done    (done),
      .done_id (done_id),
      .result  (result)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every done pulse must match the oldest pending expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (done === 1'b1) begin
         n_done++;
         check("mon_pending_op", 32'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("mon_done_id", 32'(done_id), 32'(e.id));
            check("mon_result", 32'(result), 32'(e.res));
            check("mon_grant_held", 32'(grant), 32'(1) << e.id);
         end
      end
   end

   task automatic wait_grant(input string name, input logic [1:0] exp_g);
      int c = 0;
      while (grant == 2'b00 && c < 20) begin
         @(negedge clk);
         c++;
      end
      check({name, "_grant"}, 32'(grant), 32'(exp_g));
      check({name, "_grant_latency"}, 32'(c), 1);
   endtask

   task automatic wait_idle(input string name);
      int c = 0;
      while (busy && c < 20) begin
         c++;
         @(negedge clk);
      end
      check({name, "_busy_cycles"}, 32'(c), 32'(WIDTH + 1));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int done_before;
      reset = 1'b1;
      req   = '0;
      a_in  = '0;
      b_in  = '0;

      // 1: reset held two cycles, then idle
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("t1_grant", 32'(grant), 0);
      check("t1_busy", 32'(busy), 0);
      check("t1_done", 32'(done), 0);
      check("t1_result", 32'(result), 0);
      check("t1_done_id", 32'(done_id), 0);
      @(negedge clk);
      check("t1_idle_grant", 32'(grant), 0);

      // 2: single request from requester 0
      a_in[3:0] = 4'b1010;
      b_in[3:0] = 4'b0110;
      req = 2'b01;
      sb.push_back('{0, 4'b1100});
      wait_grant("t2", 2'b01);
      req = 2'b00;
      wait_idle("t2");
      check("t2_result_hold", 32'(result), 32'hC);
      check("t2_done_count", 32'(n_done), 1);

      // 3: simultaneous requests from a fresh pointer
      do_reset();
      a_in = {4'hF, 4'hA};
      b_in = {4'h3, 4'h6};
      req  = 2'b11;
      sb.push_back('{0, 4'hC});
      sb.push_back('{1, 4'hC});
      wait_grant("t3_first", 2'b01);
      req = 2'b10;
      wait_idle("t3_first");
      wait_grant("t3_second", 2'b10);
      req = 2'b00;
      wait_idle("t3_second");
      check("t3_done_count", 32'(n_done), 3);

      // 4: req0 held, req1 pulsing; grants alternate 01,10,01
      a_in = {4'h9, 4'h3};
      b_in = {4'h3, 4'h5};
      req  = 2'b11;
      sb.push_back('{0, 4'h6});
      sb.push_back('{1, 4'hA});
      sb.push_back('{0, 4'h6});
      wait_grant("t4_a", 2'b01);
      wait_idle("t4_a");
      wait_grant("t4_b", 2'b10);
      req = 2'b01;
      wait_idle("t4_b");
      wait_grant("t4_c", 2'b01);
      req = 2'b00;
      wait_idle("t4_c");

      // 5: reset during the third SHIFT cycle aborts without a done pulse
      done_before = n_done;
      a_in[3:0] = 4'hB;
      b_in[3:0] = 4'h4;
      req = 2'b01;
      wait_grant("t5_pre", 2'b01);
      req = 2'b00;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("t5_rst_grant", 32'(grant), 0);
      check("t5_rst_busy", 32'(busy), 0);
      check("t5_rst_done", 32'(done), 0);
      check("t5_rst_result", 32'(result), 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_no_done", 32'(n_done), 32'(done_before));
      sb.push_back('{0, 4'hF});
      req = 2'b01;
      wait_grant("t5_post", 2'b01);
      req = 2'b00;
      wait_idle("t5_post");

      // 6: operands and req changed right after grant have no effect
      a_in[3:0] = 4'h5;
      b_in[3:0] = 4'hC;
      req = 2'b01;
      sb.push_back('{0, 4'h9});
      wait_grant("t6", 2'b01);
      a_in[3:0] = 4'hF;
      b_in[3:0] = 4'h0;
      req = 2'b00;
      wait_idle("t6");
      check("t6_result_hold", 32'(result), 32'h9);

      @(negedge clk);
      check("sb_drained", 32'(sb.size()), 0);
      check("total_done", 32'(n_done), 8);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
